// File: rtl/vecunit_fpadd_pkg.sv
// Shared types and default sizing for the vector FP32 add/sub element sequencer.
package vecunit_fpadd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int EW_DEF         = 32;
  localparam int VL_W_DEF       = 8;
  localparam int LAT_DEF        = 3;
  localparam int FIFO_DEPTH_DEF = 8;

  // Width of a counter that must be able to hold the value `depth` itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fpadd_vec_sequencer_if.sv
// Command, operand, adder and result signals of the FP32 add/sub element sequencer.
interface fpadd_vec_sequencer_if
  import vecunit_fpadd_pkg::*;
#(
  parameter int EW   = EW_DEF,
  parameter int VL_W = VL_W_DEF
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [VL_W-1:0] cmd_vl_i;
  logic            cmd_op_i;
  logic            opnd_valid_i;
  logic            opnd_ready_o;
  logic [EW-1:0]   opa_i;
  logic [EW-1:0]   opb_i;
  logic            fpu_valid_o;
  logic [EW-1:0]   fpu_a_o;
  logic [EW-1:0]   fpu_b_o;
  logic            fpu_op_o;
  logic [EW-1:0]   fpu_res_i;
  logic            fpu_inf_nan_i;
  logic            fpu_den_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [EW-1:0]   res_data_o;
  logic            res_last_o;
  logic            busy_o;
  logic            done_o;
  logic            exc_inf_nan_o;
  logic            exc_den_o;

  modport slave (
    input  cmd_valid_i, cmd_vl_i, cmd_op_i, opnd_valid_i, opa_i, opb_i,
           fpu_res_i, fpu_inf_nan_i, fpu_den_i, res_ready_i,
    output cmd_ready_o, opnd_ready_o, fpu_valid_o, fpu_a_o, fpu_b_o, fpu_op_o,
           res_valid_o, res_data_o, res_last_o, busy_o, done_o,
           exc_inf_nan_o, exc_den_o
  );

  modport master (
    output cmd_valid_i, cmd_vl_i, cmd_op_i, opnd_valid_i, opa_i, opb_i,
           fpu_res_i, fpu_inf_nan_i, fpu_den_i, res_ready_i,
    input  cmd_ready_o, opnd_ready_o, fpu_valid_o, fpu_a_o, fpu_b_o, fpu_op_o,
           res_valid_o, res_data_o, res_last_o, busy_o, done_o,
           exc_inf_nan_o, exc_den_o
  );

endinterface

// File: rtl/fpadd_res_fifo.sv
// Synchronous result FIFO with occupancy count; storage is not reset, only pointers and count.
module fpadd_res_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap explicitly so non-power-of-two depths work.
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fpadd_vec_sequencer.sv
// Streams one vector add/sub command through a fixed-latency FP32 adder, buffering
// results with credit-based backpressure and collecting sticky exception flags.
module fpadd_vec_sequencer
  import vecunit_fpadd_pkg::*;
#(
  parameter int EW         = EW_DEF,
  parameter int VL_W       = VL_W_DEF,
  parameter int LAT        = LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fpadd_vec_sequencer_if.slave  bus
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  state_e          state_q, state_d;
  logic            op_q, op_d;
  logic [VL_W-1:0] remaining_q, remaining_d;
  logic [VL_W-1:0] elem_total_q, elem_total_d;
  logic [VL_W-1:0] wr_ord_q, wr_ord_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic            inf_q, inf_d;
  logic            den_q, den_d;

  logic [CW-1:0]   fifo_cnt;
  logic [EW:0]     fifo_head;
  logic [CW:0]     occupancy;
  logic            credit, issue, push, pop, push_last, res_valid;

  // Credit counts elements already in the adder as well as those queued, so the
  // FIFO can never be over-committed; a same-cycle pop deliberately frees nothing.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign credit    = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == ST_ISSUE) && credit && bus.opnd_valid_i;
  assign push      = vld_q[LAT-1];
  assign push_last = (wr_ord_q + VL_W'(1)) == elem_total_q;
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && bus.res_ready_i;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    remaining_d  = remaining_q;
    elem_total_d = elem_total_q;
    wr_ord_d     = wr_ord_q;
    inflight_d   = inflight_q;
    inf_d        = inf_q;
    den_d        = den_q;
    vld_d[0]     = issue;
    for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];

    if (push) begin
      wr_ord_d = wr_ord_q + VL_W'(1);
      inf_d    = inf_q | bus.fpu_inf_nan_i;
      den_d    = den_q | bus.fpu_den_i;
    end

    case ({issue, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          op_d         = bus.cmd_op_i;
          remaining_d  = bus.cmd_vl_i;
          elem_total_d = bus.cmd_vl_i;
          wr_ord_d     = '0;
          inf_d        = 1'b0;
          den_d        = 1'b0;
          state_d      = (bus.cmd_vl_i != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          remaining_d = remaining_q - VL_W'(1);
          if (remaining_q == VL_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) && (fifo_cnt == '0) && !push) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      remaining_q  <= '0;
      elem_total_q <= '0;
      wr_ord_q     <= '0;
      inflight_q   <= '0;
      vld_q        <= '0;
      inf_q        <= 1'b0;
      den_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      remaining_q  <= remaining_d;
      elem_total_q <= elem_total_d;
      wr_ord_q     <= wr_ord_d;
      inflight_q   <= inflight_d;
      vld_q        <= vld_d;
      inf_q        <= inf_d;
      den_q        <= den_d;
    end
  end

  fpadd_res_fifo #(
    .WIDTH (EW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  ({bus.fpu_res_i, push_last}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign bus.cmd_ready_o   = (state_q == ST_IDLE);
  assign bus.opnd_ready_o  = (state_q == ST_ISSUE) && credit;
  assign bus.fpu_valid_o   = issue;
  assign bus.fpu_a_o       = issue ? bus.opa_i : '0;
  assign bus.fpu_b_o       = issue ? bus.opb_i : '0;
  assign bus.fpu_op_o      = op_q;
  assign bus.res_valid_o   = res_valid;
  assign bus.res_data_o    = res_valid ? fifo_head[EW:1] : '0;
  assign bus.res_last_o    = res_valid && fifo_head[0];
  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.done_o        = (state_q == ST_DONE);
  assign bus.exc_inf_nan_o = inf_q;
  assign bus.exc_den_o     = den_q;

endmodule

// File: tb/tb_fpadd_vec_sequencer.sv
// Scoreboard bench: driver pushes expected results, an independent monitor pops and compares.
module tb_fpadd_vec_sequencer;
  import vecunit_fpadd_pkg::*;

  localparam int EW    = 32;
  localparam int VL_W  = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpadd_vec_sequencer_if #(.EW(EW), .VL_W(VL_W)) bus();

  fpadd_vec_sequencer #(.EW(EW), .VL_W(VL_W), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d (t=%0t)", name, v, lo, hi, $time);
    end
  endtask

  // FP32 reference arithmetic via double precision (normal operands only).
  function automatic real to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic op);
    return to_fp32(op ? (to_real(a) - to_real(b)) : (to_real(a) + to_real(b)));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(120, 134));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Adder model: LAT-cycle pipeline with per-command flag injection by element ordinal.
  typedef struct packed { logic v; logic [31:0] r; logic inf; logic den; } pipe_t;
  pipe_t pipe [LAT] = '{default: '0};
  int    iss_ord = 0;
  int    inf_idx = 0;
  int    den_idx = 0;

  initial forever begin
    @(posedge clk);
    if (bus.cmd_valid_i && bus.cmd_ready_o) iss_ord <= 0;
    else if (bus.fpu_valid_o) iss_ord <= iss_ord + 1;
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= '{v:   bus.fpu_valid_o,
                 r:   fp_op(bus.fpu_a_o, bus.fpu_b_o, bus.fpu_op_o),
                 inf: bus.fpu_valid_o && (iss_ord + 1 == inf_idx),
                 den: bus.fpu_valid_o && (iss_ord + 1 == den_idx)};
  end

  assign bus.fpu_res_i     = pipe[LAT-1].r;
  assign bus.fpu_inf_nan_i = pipe[LAT-1].inf;
  assign bus.fpu_den_i     = pipe[LAT-1].den;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard and monitor state
  logic [32:0] exp_q [$];
  int   n_issued = 0, n_flushed = 0;
  int   n_popped = 0, n_last = 0, n_done = 0;
  int   rise_cyc = 0, last_pop_cyc = 0, done_cyc = 0;
  logic done_inf = 1'b0, done_den = 1'b0, prev_valid = 1'b0;
  logic rand_ready = 1'b0;

  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.res_valid_o && !prev_valid) rise_cyc = cyc;
      prev_valid = bus.res_valid_o;
      if (bus.res_valid_o && bus.res_ready_i) begin
        chk_rng("outstanding", n_issued - n_flushed - n_popped, 1, DEPTH);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none", bus.res_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", 64'(bus.res_data_o), 64'(e[32:1]));
          chk("res_last", 64'(bus.res_last_o), 64'(e[0]));
        end
        n_popped++;
        last_pop_cyc = cyc;
        if (bus.res_last_o) n_last++;
      end
      if (bus.done_o) begin
        n_done++;
        done_cyc = cyc;
        done_inf = bus.exc_inf_nan_o;
        done_den = bus.exc_den_o;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_ready) bus.res_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Driver state
  int   cur_vl = 0, cur_ord = 0, accept_cyc = 0, first_issue_cyc = 0;
  logic cur_op = OP_ADD;

  task automatic start_cmd(input int vl, input logic op);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_vl_i    = VL_W'(vl);
    bus.cmd_op_i    = op;
    #1;
    chk("cmd_ready_at_accept", 64'(bus.cmd_ready_o), 64'd1);
    accept_cyc = cyc;
    cur_vl     = vl;
    cur_op     = op;
    cur_ord    = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expd,
                           input int gap, output logic ok);
    int budget;
    repeat (gap) begin
      @(negedge clk);
      bus.opnd_valid_i = 1'b0;
    end
    @(negedge clk);
    bus.opnd_valid_i = 1'b1;
    bus.opa_i        = a;
    bus.opb_i        = b;
    budget = 0;
    ok     = 1'b0;
    while (budget < 60) begin
      #1;
      if (bus.opnd_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      budget++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL opnd_handshake_timeout actual=0 required=1");
      bus.opnd_valid_i = 1'b0;
    end else begin
      cur_ord++;
      if (cur_ord == 1) first_issue_cyc = cyc;
      exp_q.push_back({expd, cur_ord == cur_vl});
      n_issued++;
    end
  endtask

  task automatic idle_opnd();
    @(negedge clk);
    bus.opnd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int rdy_seen);
    int n;
    n = 0;
    rdy_seen = 0;
    while (n < budget) begin
      @(negedge clk);
      #1;
      if (bus.opnd_ready_o) rdy_seen++;
      if (bus.done_o) break;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int   s_pop, s_last, s_done, rdy, cnt;
    logic ok;
    logic [31:0] a, b;

    bus.cmd_valid_i  = 1'b0;
    bus.cmd_vl_i     = '0;
    bus.cmd_op_i     = OP_ADD;
    bus.opnd_valid_i = 1'b0;
    bus.opa_i        = '0;
    bus.opb_i        = '0;
    bus.res_ready_i  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_opnd_ready", 64'(bus.opnd_ready_o), 64'd0);
    chk("rst_fpu_valid", 64'(bus.fpu_valid_o), 64'd0);
    chk("rst_exc", 64'({bus.exc_inf_nan_o, bus.exc_den_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // vl=4 add, 1.0 + 2.0
    s_pop = n_popped; s_last = n_last; s_done = n_done;
    start_cmd(4, OP_ADD);
    for (int i = 0; i < 4; i++) send_pair(32'h3F800000, 32'h40000000, 32'h40400000, 0, ok);
    idle_opnd();
    wait_done(100, rdy);
    repeat (3) @(negedge clk);
    #2;
    chk("t1_first_latency", 64'(rise_cyc - first_issue_cyc), 64'(LAT + 1));
    chk("t1_consecutive", 64'(last_pop_cyc - rise_cyc), 64'd3);
    chk("t1_pops", 64'(n_popped - s_pop), 64'd4);
    chk("t1_last_count", 64'(n_last - s_last), 64'd1);
    chk("t1_done_count", 64'(n_done - s_done), 64'd1);
    chk_rng("t1_done_after_pop", done_cyc - last_pop_cyc, 1, 2);
    chk("t1_exc", 64'({done_inf, done_den}), 64'd0);

    // vl=0
    s_pop = n_popped; s_done = n_done;
    start_cmd(0, OP_ADD);
    wait_done(20, rdy);
    chk_rng("t2_done_after_accept", done_cyc - accept_cyc, 1, 2);
    @(negedge clk);
    #1;
    chk("t2_cmd_ready_back", 64'(bus.cmd_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("t2_no_opnd_ready", 64'(rdy), 64'd0);
    chk("t2_no_results", 64'(n_popped - s_pop), 64'd0);
    chk("t2_done_count", 64'(n_done - s_done), 64'd1);

    // vl=12 with sink stalled: credit limits issues to DEPTH
    s_pop = n_popped; s_last = n_last;
    bus.res_ready_i = 1'b0;
    start_cmd(12, OP_ADD);
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a = rnd_fp(); b = rnd_fp();
      send_pair(a, b, fp_op(a, b, OP_ADD), 0, ok);
      if (ok) cnt++;
    end
    chk("t3_issued_before_stall", 64'(cnt), 64'(DEPTH));
    @(negedge clk);
    bus.opnd_valid_i = 1'b1;
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.opnd_ready_o) rdy++;
      @(negedge clk);
    end
    chk("t3_stalled_ready", 64'(rdy), 64'd0);
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 12 - DEPTH; i++) begin
      a = rnd_fp(); b = rnd_fp();
      send_pair(a, b, fp_op(a, b, OP_ADD), 0, ok);
    end
    idle_opnd();
    wait_done(200, rdy);
    repeat (2) @(negedge clk);
    chk("t3_pops", 64'(n_popped - s_pop), 64'd12);
    chk("t3_last_count", 64'(n_last - s_last), 64'd1);

    // vl=3 sub with injected exceptions
    inf_idx = 2;
    den_idx = 3;
    start_cmd(3, OP_SUB);
    for (int i = 0; i < 3; i++) begin
      a = rnd_fp(); b = rnd_fp();
      send_pair(a, b, fp_op(a, b, OP_SUB), 0, ok);
    end
    idle_opnd();
    wait_done(100, rdy);
    #1;
    chk("t4_inf_at_done", 64'(done_inf), 64'd1);
    chk("t4_den_at_done", 64'(done_den), 64'd1);
    @(negedge clk);
    #1;
    chk("t4_exc_held", 64'({bus.exc_inf_nan_o, bus.exc_den_o}), 64'b11);
    inf_idx = 0;
    den_idx = 0;

    // Async reset mid-command
    bus.res_ready_i = 1'b0;
    start_cmd(6, OP_ADD);
    chk("t5_exc_cleared_on_accept", 64'({bus.exc_inf_nan_o, bus.exc_den_o}), 64'd0);
    a = rnd_fp(); b = rnd_fp();
    send_pair(a, b, fp_op(a, b, OP_ADD), 0, ok);
    a = rnd_fp(); b = rnd_fp();
    send_pair(a, b, fp_op(a, b, OP_ADD), 1, ok);
    idle_opnd();
    cnt = 0;
    while (!bus.res_valid_o && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("t5_one_result_queued", 64'(bus.res_valid_o), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("t5_rst_res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("t5_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("t5_rst_exc", 64'({bus.exc_inf_nan_o, bus.exc_den_o}), 64'd0);
    n_flushed = n_issued - n_popped;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.res_valid_o) cnt++;
      @(negedge clk);
    end
    chk("t5_late_results_dropped", 64'(cnt), 64'd0);
    bus.res_ready_i = 1'b1;
    s_pop = n_popped; s_last = n_last; s_done = n_done;
    start_cmd(2, OP_ADD);
    for (int i = 0; i < 2; i++) begin
      a = rnd_fp(); b = rnd_fp();
      send_pair(a, b, fp_op(a, b, OP_ADD), 0, ok);
    end
    idle_opnd();
    wait_done(100, rdy);
    repeat (2) @(negedge clk);
    chk("t5_post_pops", 64'(n_popped - s_pop), 64'd2);
    chk("t5_post_last", 64'(n_last - s_last), 64'd1);
    chk("t5_post_done", 64'(n_done - s_done), 64'd1);

    // vl=200 with random gaps on both sides
    s_pop = n_popped; s_last = n_last; s_done = n_done;
    rand_ready = 1'b1;
    cur_op = 1'($urandom);
    start_cmd(200, cur_op);
    for (int i = 0; i < 200; i++) begin
      a = rnd_fp(); b = rnd_fp();
      send_pair(a, b, fp_op(a, b, cur_op), $urandom_range(0, 2), ok);
    end
    idle_opnd();
    wait_done(4000, rdy);
    rand_ready = 1'b0;
    @(negedge clk);
    #2;
    bus.res_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_pops", 64'(n_popped - s_pop), 64'd200);
    chk("t6_last_count", 64'(n_last - s_last), 64'd1);
    chk("t6_done_count", 64'(n_done - s_done), 64'd1);
    chk("t6_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
